// File: rtl/cga_dbl_pkg.sv
// rtl/cga_dbl_pkg.sv - shared defaults and read-FSM encoding for the CGA line doubler
package cga_dbl_pkg;

  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_HSYNC_W = 112;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_PASS0 = 2'd1,
    RD_PASS1 = 2'd2
  } rd_state_e;

endpackage

// File: rtl/cga_dbl_linebuf.sv
// rtl/cga_dbl_linebuf.sv - two-bank line buffer, one write port, one registered read port
module cga_dbl_linebuf
  import cga_dbl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [ADDR_W:0] wr_addr,
  input  logic [3:0]      wr_data,
  input  logic [ADDR_W:0] rd_addr,
  output logic [3:0]      rd_data
);

  // MSB of each address selects the bank
  logic [3:0] mem [0:(2**(ADDR_W+1))-1];

  // Plain write plus registered read, no reset, so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cga_line_doubler.sv
// rtl/cga_line_doubler.sv - CGA scanline doubler: ping-pong capture, double-rate replay
module cga_line_doubler
  import cga_dbl_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int HSYNC_W = DEF_HSYNC_W
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       line_reset,
  input  logic [3:0] video,
  output logic [3:0] dbl_video,
  output logic       dbl_hsync,
  output logic       overflow
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam int                HS_W     = $clog2(HSYNC_W + 1);
  localparam logic [HS_W-1:0]   HS_LOAD  = HS_W'(HSYNC_W);

  logic              lr_d1, lr_d2, lr_edge;
  logic              wr_phase, wbank, wr_en;
  logic [ADDR_W-1:0] wr_addr, len;
  rd_state_e         state, state_nxt;
  logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
  logic [3:0]        ram_q;
  logic              active0, pass_start, act1, hs1;
  logic [HS_W-1:0]   hs_cnt, hs_cur;

  assign lr_edge = lr_d1 & ~lr_d2;

  // Register line_reset and its previous value; the edge acts one clk later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lr_d1 <= 1'b0;
      lr_d2 <= 1'b0;
    end else begin
      lr_d1 <= line_reset;
      lr_d2 <= lr_d1;
    end
  end

  // A pixel is stored every other clk until the bank is full
  assign wr_en = wr_phase && (wr_addr != ADDR_MAX);

  // Write counter, bank swap and overflow; a line edge wins over a same-cycle write update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_phase <= 1'b0;
      wr_addr  <= '0;
      wbank    <= 1'b0;
      len      <= '0;
      overflow <= 1'b0;
    end else if (lr_edge) begin
      len      <= wr_addr;
      wbank    <= ~wbank;
      wr_addr  <= '0;
      wr_phase <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_phase <= ~wr_phase;
      if (wr_phase) begin
        if (wr_addr != ADDR_MAX) begin
          wr_addr <= wr_addr + ADDR_W'(1);
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  cga_dbl_linebuf #(.ADDR_W(ADDR_W)) u_linebuf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr ({wbank, wr_addr}),
    .wr_data (video),
    .rd_addr ({~wbank, rd_addr}),
    .rd_data (ram_q)
  );

  // Read FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RD_IDLE;
      rd_addr <= '0;
    end else begin
      state   <= state_nxt;
      rd_addr <= rd_addr_nxt;
    end
  end

  // Read FSM next state: a line edge restarts PASS0, otherwise walk two passes of len pixels
  always_comb begin
    state_nxt   = state;
    rd_addr_nxt = rd_addr;
    if (lr_edge) begin
      rd_addr_nxt = '0;
      state_nxt   = (wr_addr == '0) ? RD_IDLE : RD_PASS0;
    end else begin
      case (state)
        RD_PASS0: begin
          if (rd_addr == len - ADDR_W'(1)) begin
            rd_addr_nxt = '0;
            state_nxt   = RD_PASS1;
          end else begin
            rd_addr_nxt = rd_addr + ADDR_W'(1);
          end
        end
        RD_PASS1: begin
          if (rd_addr == len - ADDR_W'(1)) begin
            rd_addr_nxt = '0;
            state_nxt   = RD_IDLE;
          end else begin
            rd_addr_nxt = rd_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Sync count is reloaded at every pass start, so short lines keep hsync high throughout
  assign active0    = (state != RD_IDLE);
  assign pass_start = active0 && (rd_addr == '0);
  assign hs_cur     = pass_start ? HS_LOAD : hs_cnt;

  // Remaining hsync cycles after the current one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_cnt <= '0;
    end else if (!active0 || (hs_cur == '0)) begin
      hs_cnt <= '0;
    end else begin
      hs_cnt <= hs_cur - HS_W'(1);
    end
  end

  // Delay active/hsync alongside the RAM read, then register the outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act1      <= 1'b0;
      hs1       <= 1'b0;
      dbl_video <= '0;
      dbl_hsync <= 1'b0;
    end else begin
      act1      <= active0;
      hs1       <= active0 && (hs_cur != '0);
      dbl_video <= act1 ? ram_q : 4'h0;
      dbl_hsync <= hs1;
    end
  end

endmodule
